// File: rtl/axi_vga_pkg.sv
// Shared types and helpers for the VGA pixel path: pixel formats, bits per pixel
// and colour-field widening/narrowing.
package axi_vga_pkg;

  typedef enum logic [1:0] {
    PixRgb565   = 2'd0,
    PixXrgb8888 = 2'd1,
    PixRgb332   = 2'd2,
    PixPal4     = 2'd3
  } pix_mode_e;

  function automatic int bpp(pix_mode_e mode);
    case (mode)
      PixRgb565:   return 16;
      PixXrgb8888: return 32;
      PixRgb332:   return 8;
      default:     return 4;
    endcase
  endfunction

  // Result is right-aligned in the low dst_w bits. Narrowing keeps the field MSBs;
  // widening repeats the field from its MSB downwards until dst_w bits are filled.
  function automatic logic [7:0] expand(logic [7:0] field, int src_w, int dst_w);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < dst_w) res[3'(dst_w - 1 - i)] = field[3'(src_w - 1 - (i % src_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_vga_palette.sv
// 16-entry x 24-bit colour palette: one write port, one combinational read port.
// A read in the same cycle as a write to that entry returns the previous contents.
module axi_vga_palette (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [23:0] wdata,
  input  logic [3:0]  raddr,
  output logic [23:0] rdata
);

  logic [23:0] mem_q [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < 16; e++) mem_q[e] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_vga_pixel_unpacker.sv
// Unpacks framebuffer words into one pixel per cycle in RGB565, XRGB8888, RGB332
// or 4bpp-palette format, LSB pixel first, for the VGA timing stage.
module axi_vga_pixel_unpacker
  import axi_vga_pkg::*;
#(
  parameter int DataWidth  = 64,
  parameter int RedWidth   = 8,
  parameter int GreenWidth = 8,
  parameter int BlueWidth  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            mode_i,
  input  logic                  flush_i,
  input  logic [DataWidth-1:0]  word_i,
  input  logic                  word_last_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  input  logic                  pal_we_i,
  input  logic [3:0]            pal_addr_i,
  input  logic [23:0]           pal_data_i,
  output logic [RedWidth-1:0]   red_o,
  output logic [GreenWidth-1:0] green_o,
  output logic [BlueWidth-1:0]  blue_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int IdxW = $clog2(DataWidth / 4) + 1;

  logic [DataWidth-1:0] word_q;
  logic                 last_q;
  logic                 full_q;
  logic                 frame_start_q;
  logic [IdxW-1:0]      idx_q;
  pix_mode_e            mode_q;

  logic [IdxW-1:0] idx_last;
  logic            at_end;
  logic            pix_fire;
  logic            word_fire;
  int              shamt;
  logic [23:0]     pix_bits;
  logic [23:0]     pal_rgb;
  logic [7:0]      red8;
  logic [7:0]      green8;
  logic [7:0]      blue8;

  // Both streams use valid/ready: a transfer happens on a rising clk_i edge where
  // valid and ready are both high; a raised valid and its payload hold until then.
  always_comb begin
    idx_last = IdxW'(DataWidth / bpp(mode_q) - 1);
  end

  assign at_end       = (idx_q == idx_last);
  assign pix_fire     = full_q && ready_i;
  assign word_ready_o = !flush_i && (!full_q || (ready_i && at_end));
  assign word_fire    = word_valid_i && word_ready_o;
  assign valid_o      = full_q;
  assign last_o       = last_q && at_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q        <= '0;
      last_q        <= 1'b0;
      full_q        <= 1'b0;
      frame_start_q <= 1'b1;
      idx_q         <= '0;
      mode_q        <= PixRgb565;
    end else if (flush_i) begin
      full_q        <= 1'b0;
      idx_q         <= '0;
      frame_start_q <= 1'b1;
    end else if (word_fire) begin
      // Accepting while full only happens on the final pixel, so nothing is lost.
      word_q        <= word_i;
      last_q        <= word_last_i;
      full_q        <= 1'b1;
      idx_q         <= '0;
      frame_start_q <= word_last_i;
      if (frame_start_q) mode_q <= pix_mode_e'(mode_i);
    end else if (pix_fire) begin
      if (at_end) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    shamt    = int'(idx_q) * bpp(mode_q);
    pix_bits = 24'(word_q >> shamt);
    red8     = '0;
    green8   = '0;
    blue8    = '0;
    case (mode_q)
      PixRgb565: begin
        red8   = expand({3'b0, pix_bits[15:11]}, 5, RedWidth);
        green8 = expand({2'b0, pix_bits[10:5]},  6, GreenWidth);
        blue8  = expand({3'b0, pix_bits[4:0]},   5, BlueWidth);
      end
      PixXrgb8888: begin
        red8   = expand(pix_bits[23:16], 8, RedWidth);
        green8 = expand(pix_bits[15:8],  8, GreenWidth);
        blue8  = expand(pix_bits[7:0],   8, BlueWidth);
      end
      PixRgb332: begin
        red8   = expand({5'b0, pix_bits[7:5]}, 3, RedWidth);
        green8 = expand({5'b0, pix_bits[4:2]}, 3, GreenWidth);
        blue8  = expand({6'b0, pix_bits[1:0]}, 2, BlueWidth);
      end
      default: begin
        red8   = expand(pal_rgb[23:16], 8, RedWidth);
        green8 = expand(pal_rgb[15:8],  8, GreenWidth);
        blue8  = expand(pal_rgb[7:0],   8, BlueWidth);
      end
    endcase
  end

  assign red_o   = red8[RedWidth-1:0];
  assign green_o = green8[GreenWidth-1:0];
  assign blue_o  = blue8[BlueWidth-1:0];

  axi_vga_palette u_palette (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (pal_we_i),
    .waddr (pal_addr_i),
    .wdata (pal_data_i),
    .raddr (pix_bits[3:0]),
    .rdata (pal_rgb)
  );

endmodule
